// File: rtl/ddr3_lfsr_tester.sv
// LFSR-pattern write/read-back traffic generator for the DDR3 controller Avalon-MM local port.
// Optional macro DDR3_TESTER_ERR_COUNT_EN adds err_count and checks the whole region before DONE.
module ddr3_lfsr_tester #(
  parameter int unsigned NUM_WORDS = 1024,
  parameter int unsigned BURST_LEN = 4,
  parameter logic [31:0] SEED      = 32'hACE1_2345,
  localparam int unsigned ADDR_W   = 24,
  localparam int unsigned DATA_W   = 64,
  localparam int unsigned BE_W     = 8,
  localparam int unsigned SIZE_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avl_ready,
  output logic              avl_burstbegin,
  output logic [ADDR_W-1:0] avl_addr,
  input  logic              avl_rdata_valid,
  input  logic [DATA_W-1:0] avl_rdata,
  output logic [DATA_W-1:0] avl_wdata,
  output logic [BE_W-1:0]   avl_be,
  output logic              avl_read_req,
  output logic              avl_write_req,
  output logic [SIZE_W-1:0] avl_size,
  input  logic              ddr3_init_done,
  input  logic              ddr3_cal_success,
  input  logic              ddr3_cal_fail,
  output logic              is_finished,
  output logic              pass,
`ifdef DDR3_TESTER_ERR_COUNT_EN
  output logic [15:0]       err_count,
`endif
  output logic              fail
);

  localparam int unsigned LFSR_W = 32;
  localparam int unsigned BEAT_W = 6;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [ADDR_W-1:0] BASE_INC  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(NUM_WORDS - BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [SIZE_W-1:0] SIZE_VAL  = SIZE_W'(BURST_LEN);

  typedef enum logic [2:0] {
    WAIT_CAL  = 3'd0,
    WRITE     = 3'd1,
    READ_REQ  = 3'd2,
    READ_DATA = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                err_q, err_d;
`ifdef DDR3_TESTER_ERR_COUNT_EN
  logic [15:0]         err_cnt_d;
`endif

  logic                burstbegin_d, read_req_d, write_req_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [BE_W-1:0]     be_d;
  logic [SIZE_W-1:0]   size_d;
  logic                finished_d, pass_d, fail_d;

  logic [LFSR_W-1:0]   lfsr_step;
  logic [DATA_W-1:0]   exp_word;
  logic                mismatch;
  logic                spurious;

  // Right-shift Galois form of x^32+x^22+x^2+x+1
  always_comb begin
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    exp_word  = {lfsr_q, ~lfsr_q};
    mismatch  = (state_q == READ_DATA) && avl_rdata_valid && (avl_rdata != exp_word);
    // Stray beats after DONE are in-flight leftovers of an aborted burst
    spurious  = avl_rdata_valid && (state_q != READ_DATA) && (state_q != DONE);
  end

  // State register, datapath counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= WAIT_CAL;
      lfsr_q         <= SEED;
      base_q         <= '0;
      beat_q         <= '0;
      err_q          <= 1'b0;
      avl_burstbegin <= 1'b0;
      avl_addr       <= '0;
      avl_wdata      <= '0;
      avl_be         <= '0;
      avl_read_req   <= 1'b0;
      avl_write_req  <= 1'b0;
      avl_size       <= '0;
      is_finished    <= 1'b0;
      pass           <= 1'b0;
      fail           <= 1'b0;
`ifdef DDR3_TESTER_ERR_COUNT_EN
      err_count      <= '0;
`endif
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      base_q         <= base_d;
      beat_q         <= beat_d;
      err_q          <= err_d;
      avl_burstbegin <= burstbegin_d;
      avl_addr       <= addr_d;
      avl_wdata      <= wdata_d;
      avl_be         <= be_d;
      avl_read_req   <= read_req_d;
      avl_write_req  <= write_req_d;
      avl_size       <= size_d;
      is_finished    <= finished_d;
      pass           <= pass_d;
      fail           <= fail_d;
`ifdef DDR3_TESTER_ERR_COUNT_EN
      err_count      <= err_cnt_d;
`endif
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    base_d  = base_q;
    beat_d  = beat_q;
    err_d   = err_q;
`ifdef DDR3_TESTER_ERR_COUNT_EN
    err_cnt_d = err_count;
`endif

    unique case (state_q)
      WAIT_CAL: begin
        if (ddr3_cal_fail) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (ddr3_init_done && ddr3_cal_success) begin
          state_d = WRITE;
        end
      end

      WRITE: begin
        if (avl_ready) begin
          lfsr_d = lfsr_step;
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (base_q == LAST_BASE) begin
              base_d  = '0;
              lfsr_d  = SEED;
              state_d = READ_REQ;
            end else begin
              base_d = base_q + BASE_INC;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end

      READ_REQ: begin
        if (avl_ready) begin
          beat_d  = '0;
          state_d = READ_DATA;
        end
      end

      READ_DATA: begin
        if (avl_rdata_valid) begin
          lfsr_d = lfsr_step;
          if (mismatch) begin
            err_d = 1'b1;
          end
          if (beat_q == LAST_BEAT) begin
            beat_d = '0;
            if (base_q == LAST_BASE) begin
              state_d = DONE;
            end else begin
              base_d  = base_q + BASE_INC;
              state_d = READ_REQ;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
`ifndef DDR3_TESTER_ERR_COUNT_EN
          if (mismatch) begin
            state_d = DONE;
          end
`endif
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = WAIT_CAL;
      end
    endcase

    if (spurious) begin
      err_d = 1'b1;
    end
`ifdef DDR3_TESTER_ERR_COUNT_EN
    if ((mismatch || spurious) && (err_count != 16'hFFFF)) begin
      err_cnt_d = err_count + 16'd1;
    end
`endif
  end

  // Output decode of the upcoming state, captured by the output registers
  always_comb begin
    burstbegin_d = 1'b0;
    read_req_d   = 1'b0;
    write_req_d  = 1'b0;
    addr_d       = '0;
    wdata_d      = '0;
    be_d         = '0;
    size_d       = '0;
    finished_d   = 1'b0;
    pass_d       = 1'b0;
    fail_d       = 1'b0;

    unique case (state_d)
      WRITE: begin
        write_req_d  = 1'b1;
        burstbegin_d = (beat_d == '0);
        addr_d       = base_d;
        wdata_d      = {lfsr_d, ~lfsr_d};
        be_d         = 8'hFF;
        size_d       = SIZE_VAL;
      end
      READ_REQ: begin
        read_req_d   = 1'b1;
        burstbegin_d = 1'b1;
        addr_d       = base_d;
        size_d       = SIZE_VAL;
      end
      DONE: begin
        finished_d = 1'b1;
        pass_d     = !err_d;
        fail_d     = err_d;
      end
      default: begin
        finished_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ddr3_lfsr_tester.sv
// Directed bench for ddr3_lfsr_tester: scenario table against a memory responder model,
// plus hand sequences for reset state, first-request latency and reset during a stalled write.
module tb_ddr3_lfsr_tester;

  localparam int NW    = 16;
  localparam int BL    = 4;
  localparam int LIMIT = 3000;
  localparam int NVEC  = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        avl_ready;
  logic        avl_burstbegin;
  logic [23:0] avl_addr;
  logic        avl_rdata_valid;
  logic [63:0] avl_rdata;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;
  logic        avl_read_req;
  logic        avl_write_req;
  logic [6:0]  avl_size;
  logic        ddr3_init_done;
  logic        ddr3_cal_success;
  logic        ddr3_cal_fail;
  logic        is_finished;
  logic        pass;
  logic        fail;
`ifdef DDR3_TESTER_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  ddr3_lfsr_tester #(.NUM_WORDS(NW), .BURST_LEN(BL), .SEED(32'hACE1_2345)) dut (
    .clk              (clk),
    .reset            (reset),
    .avl_ready        (avl_ready),
    .avl_burstbegin   (avl_burstbegin),
    .avl_addr         (avl_addr),
    .avl_rdata_valid  (avl_rdata_valid),
    .avl_rdata        (avl_rdata),
    .avl_wdata        (avl_wdata),
    .avl_be           (avl_be),
    .avl_read_req     (avl_read_req),
    .avl_write_req    (avl_write_req),
    .avl_size         (avl_size),
    .ddr3_init_done   (ddr3_init_done),
    .ddr3_cal_success (ddr3_cal_success),
    .ddr3_cal_fail    (ddr3_cal_fail),
    .is_finished      (is_finished),
    .pass             (pass),
`ifdef DDR3_TESTER_ERR_COUNT_EN
    .err_count        (err_count),
`endif
    .fail             (fail)
  );

  typedef struct {
    bit stall;       // random avl_ready and 3..20 cycle read latency
    int corrupt;     // read beat index whose bit 0 is flipped, -1 none
    bit spurious;    // inject one avl_rdata_valid during WRITE
    bit cal_fail;    // calibration fails instead of succeeding
    bit exp_pass;
    bit exp_fail;
    int exp_writes;
    int exp_bursts;
    int exp_beats;
    int exp_errs;
    int fin_limit;
    bit chk_lag;
  } vec_t;

  vec_t        vecs[NVEC];
  logic [63:0] exp_words[NW];
  logic [63:0] mem[NW];
  int          n_vec, n_bad;
  int          wr_cnt, rd_bursts, rd_beats, seq_err, stab_err, post_reqs, fin_cyc, fin_lag;

  function automatic vec_t mk(input bit st, input int cor, input bit sp, input bit cf,
                              input bit ep, input bit ef, input int ew, input int eb,
                              input int ebt, input int ee, input int fl, input bit cl);
    vec_t v;
    v.stall = st; v.corrupt = cor; v.spurious = sp; v.cal_fail = cf;
    v.exp_pass = ep; v.exp_fail = ef; v.exp_writes = ew; v.exp_bursts = eb;
    v.exp_beats = ebt; v.exp_errs = ee; v.fin_limit = fl; v.chk_lag = cl;
    return v;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    logic [31:0] r;
    r = {1'b0, v[31:1]};
    if (v[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [105:0] snap();
    return {avl_write_req, avl_read_req, avl_burstbegin, avl_addr, avl_wdata, avl_be, avl_size};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic apply_reset(input bit cal_fail_in);
    reset = 1'b1;
    avl_ready = 1'b0; avl_rdata_valid = 1'b0; avl_rdata = '0;
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ddr3_init_done   = !cal_fail_in;
    ddr3_cal_success = !cal_fail_in;
    ddr3_cal_fail    = cal_fail_in;
    reset = 1'b0;
  endtask

  // Cycle-stepped memory responder; bus decisions made #1 after each posedge
  task automatic run_scenario(input vec_t s, input bit do_reset);
    int pend_left, pend_off, pend_delay, idx, cyc, last_cyc;
    logic [23:0]  pend_addr;
    logic [63:0]  data;
    logic [105:0] prev_snap;
    bit injected, prev_hold, rdy, valid, is_beat;
    wr_cnt = 0; rd_bursts = 0; rd_beats = 0; seq_err = 0; stab_err = 0; post_reqs = 0;
    fin_cyc = LIMIT + 1; fin_lag = 0;
    pend_left = 0; pend_off = 0; pend_delay = 0; pend_addr = '0;
    injected = 0; prev_hold = 0; prev_snap = '0; last_cyc = 0;
    for (int k = 0; k < NW; k++) mem[k] = '0;
    if (do_reset) apply_reset(s.cal_fail);
    cyc = 0;
    while (cyc < LIMIT && is_finished !== 1'b1) begin
      rdy = s.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      valid = 0; is_beat = 0; data = '0;
      if (pend_left > 0) begin
        if (pend_delay > 0) pend_delay--;
        else if (!s.stall || $urandom_range(0, 3) != 0) begin
          idx = int'(pend_addr) + pend_off;
          if (idx < NW) data = mem[idx[3:0]];
          else seq_err++;
          if (rd_beats == s.corrupt) data[0] = ~data[0];
          valid = 1; is_beat = 1;
        end
      end
      if (s.spurious && !injected && avl_write_req && wr_cnt == 5) begin
        valid = 1; injected = 1;
      end
      avl_ready = rdy; avl_rdata_valid = valid; avl_rdata = data;
      if (prev_hold && snap() != prev_snap) stab_err++;
      if (avl_write_req && rdy) begin
        if (wr_cnt >= NW || avl_addr != 24'((wr_cnt / BL) * BL) ||
            avl_burstbegin != (wr_cnt % BL == 0) || avl_be != 8'hFF ||
            avl_size != 7'(BL) || avl_wdata != exp_words[wr_cnt[3:0]])
          seq_err++;
        idx = int'(avl_addr) + wr_cnt % BL;
        if (idx < NW) mem[idx[3:0]] = avl_wdata;
        wr_cnt++;
      end
      if (avl_read_req && rdy) begin
        if (pend_left != 0 || avl_addr != 24'(rd_bursts * BL) || !avl_burstbegin ||
            avl_size != 7'(BL) || avl_write_req)
          seq_err++;
        pend_addr = avl_addr; pend_left = BL; pend_off = 0;
        pend_delay = s.stall ? int'($urandom_range(2, 19)) : 0;
        rd_bursts++;
      end
      if (is_beat) begin
        pend_off++; pend_left--; rd_beats++; last_cyc = cyc;
      end
      prev_hold = (avl_write_req || avl_read_req) && !rdy;
      prev_snap = snap();
      @(posedge clk);
      #1;
      cyc++;
    end
    if (is_finished === 1'b1) begin
      fin_cyc = cyc;
      fin_lag = cyc - last_cyc;
    end
    avl_ready = 1'b1; avl_rdata_valid = 1'b0; avl_rdata = '0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (avl_write_req || avl_read_req) post_reqs++;
    end
  endtask

  task automatic score(input string tag, input vec_t v);
    check({tag, "_finished"}, 64'(is_finished), 64'(1));
    check({tag, "_pass"}, 64'(pass), 64'(v.exp_pass));
    check({tag, "_fail"}, 64'(fail), 64'(v.exp_fail));
    check({tag, "_writes"}, 64'(wr_cnt), 64'(v.exp_writes));
    check({tag, "_rd_bursts"}, 64'(rd_bursts), 64'(v.exp_bursts));
    check({tag, "_rd_beats"}, 64'(rd_beats), 64'(v.exp_beats));
    check({tag, "_seq_err"}, 64'(seq_err), 64'(0));
    check({tag, "_stable"}, 64'(stab_err), 64'(0));
    check({tag, "_post_done_reqs"}, 64'(post_reqs), 64'(0));
    check({tag, "_fin_in_time"}, 64'(fin_cyc <= v.fin_limit), 64'(1));
    if (v.chk_lag) check({tag, "_fin_lag"}, 64'(fin_lag), 64'(1));
`ifdef DDR3_TESTER_ERR_COUNT_EN
    check({tag, "_err_count"}, 64'(err_count), 64'(v.exp_errs));
`endif
  endtask

  initial begin
    logic [31:0] l;
    int seen;
    n_vec = 0; n_bad = 0;
    l = 32'hACE1_2345;
    for (int k = 0; k < NW; k++) begin
      exp_words[k] = {l, ~l};
      l = lfsr_next(l);
    end

    //           st cor sp cf  ep ef  wr  bu  bt  er  limit  lag
    vecs[0] = mk(0, -1, 0, 0,  1, 0,  16, 4,  16, 0,  LIMIT, 1);
    vecs[1] = mk(1, -1, 0, 0,  1, 0,  16, 4,  16, 0,  LIMIT, 1);
`ifdef DDR3_TESTER_ERR_COUNT_EN
    vecs[2] = mk(0,  9, 0, 0,  0, 1,  16, 4,  16, 1,  LIMIT, 1);
    vecs[3] = mk(1,  9, 0, 0,  0, 1,  16, 4,  16, 1,  LIMIT, 0);
`else
    vecs[2] = mk(0,  9, 0, 0,  0, 1,  16, 3,  10, 1,  LIMIT, 1);
    vecs[3] = mk(1,  9, 0, 0,  0, 1,  16, 3,  10, 1,  LIMIT, 0);
`endif
    vecs[4] = mk(0, -1, 1, 0,  0, 1,  16, 4,  16, 1,  LIMIT, 1);
    vecs[5] = mk(0, -1, 0, 1,  0, 1,  0,  0,  0,  0,  2,     0);

    // Reset state, then idle while calibration is pending
    reset = 1'b1;
    avl_ready = 1'b0; avl_rdata_valid = 1'b0; avl_rdata = '0;
    ddr3_init_done = 1'b0; ddr3_cal_success = 1'b0; ddr3_cal_fail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", 64'({avl_write_req, avl_read_req, avl_burstbegin, avl_addr, avl_be,
                             avl_size, is_finished, pass, fail}), 64'(0));
    check("reset_wdata", avl_wdata, 64'(0));
`ifdef DDR3_TESTER_ERR_COUNT_EN
    check("reset_err_count", 64'(err_count), 64'(0));
`endif
    reset = 1'b0;
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (avl_write_req || avl_read_req || is_finished) seen++;
    end
    check("idle_before_cal", 64'(seen), 64'(0));

    // First write request one cycle after calibration is seen
    ddr3_init_done = 1'b1; ddr3_cal_success = 1'b1;
    @(posedge clk);
    #1;
    check("first_write_req", 64'(avl_write_req), 64'(1));
    check("first_burstbegin", 64'(avl_burstbegin), 64'(1));
    check("first_addr", 64'(avl_addr), 64'(0));
    check("first_wdata", avl_wdata, 64'hACE1_2345_531E_DCBA);
    check("first_be_size", 64'({avl_be, avl_size}), 64'({8'hFF, 7'd4}));
    @(posedge clk);
    #1;
    check("stall_hold_wdata", avl_wdata, 64'hACE1_2345_531E_DCBA);
    avl_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    avl_ready = 1'b0;
    check("beat2_addr", 64'(avl_addr), 64'(0));
    check("beat2_burstbegin", 64'(avl_burstbegin), 64'(0));
    check("beat2_wdata", avl_wdata, exp_words[2]);

    // Reset mid-cycle during a stalled third beat drops the request without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("midreset_write_req", 64'(avl_write_req), 64'(0));
    check("midreset_outs", 64'({avl_read_req, avl_burstbegin, avl_addr, avl_be, avl_size,
                                is_finished, pass, fail}), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    run_scenario(vecs[0], 1'b0);
    score("restart", vecs[0]);

    for (int i = 0; i < NVEC; i++) begin
      run_scenario(vecs[i], 1'b1);
      score($sformatf("v%0d", i), vecs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
